cvxif_issue_arbiter: RTL
========================

Name: cvxif_issue_arbiter

Overview:
- Shares one CVXIF-style coprocessor between NumReq hart-side requesters; sits between the per-hart cvxif request/response pairs and a single coprocessor instance.
- Round-robin arbitration of issue requests; remaps each hart's instruction ID to a local slot tag; routes results back to the owning hart by tag.
- Bounds the number of in-flight instructions to NumSlots.

Parameters:
- NumReq, 2, number of requesting harts (>=2).
- NumSlots, 4, max in-flight accepted instructions (power of 2).
- IdWidth, 3, hart-side instruction ID width.
- TagWidth, $clog2(NumSlots), coprocessor-side tag width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NumReq  per-hart issue valid.
- req_ready_o  out  NumReq  per-hart issue ready.
- req_instr_i  in  NumReq x 32  instruction word.
- req_id_i  in  NumReq x IdWidth  hart instruction ID.
- req_accept_o  out  NumReq  issue response: coprocessor accepted (valid with handshake).
- req_writeback_o  out  NumReq  issue response: a result will follow.
- cop_valid_o  out  1  issue valid to coprocessor.
- cop_ready_i  in  1  coprocessor issue ready.
- cop_instr_o  out  32  forwarded instruction.
- cop_tag_o  out  TagWidth  allocated slot tag.
- cop_accept_i  in  1  combinational issue response accept.
- cop_writeback_i  in  1  combinational issue response writeback.
- res_valid_i  in  1  coprocessor result valid.
- res_ready_o  out  1  result ready to coprocessor.
- res_tag_i  in  TagWidth  result tag.
- res_data_i  in  64  result data.
- hart_res_valid_o  out  NumReq  per-hart result valid.
- hart_res_ready_i  in  NumReq  per-hart result ready.
- hart_res_id_o  out  IdWidth  original hart ID of routed result (shared bus).
- hart_res_data_o  out  64  result data (shared bus).
- tag_err_o  out  1  one-cycle pulse: result for unallocated slot.

Behaviour:
- Reset: slot table all free, rr pointer = 0, lock clear. Outputs: req_ready_o=0, cop_valid_o=0, hart_res_valid_o=0, res_ready_o=0, tag_err_o=0, response outputs 0.
- Arbitration: round-robin starting at pointer. Winner = first valid requester at or after pointer (wrap). On a cop handshake, pointer <= winner+1 mod NumReq.
- Lock: once cop_valid_o is asserted and not accepted, the grant is held to the same hart (registered) until handshake. Valid is not withdrawn (AXI-style stability); a hart deasserting valid early is a protocol error and is not checked.
- Free slot: lowest-index free slot, taken from registered state. table_full => cop_valid_o=0, all req_ready_o=0. A slot freed this cycle is usable next cycle only.
- Issue path is combinational: cop_valid_o = winner valid & !full; req_ready_o[winner] = cop_ready_i & !full; others 0. req_accept_o/req_writeback_o are driven to the winner only, during the handshake cycle.
- Allocation: on handshake with cop_accept_i & cop_writeback_i, slot[tag] <= {busy=1, hart=winner, id=req_id}. Accept=0 or writeback=0 means nothing is allocated.
- Result routing, 0-cycle pass-through:
  - slot busy => hart_res_valid_o[slot.hart] = res_valid_i; res_ready_o = hart_res_ready_i[slot.hart]; hart_res_id_o = slot.id.
  - On result handshake, slot busy <= 0.
- Unallocated tag: res_ready_o=1 (drop), tag_err_o pulses for one cycle, no hart valid.
- Same cycle, allocate slot A and free slot B: both take effect. A==B is impossible by the registered-free rule.
- Reset mid-operation: all slots cleared, in-flight results afterwards are flagged as tag_err.

Decomposition:
- Shared package cvxif_arb_pkg holds slot_entry_t {busy, hart idx, id} and the NumSlots/IdWidth defaults.
- Sub-module rr_arbiter (NumReq, lock input, pointer register) is natural; the slot table and routing stay in the top.

Test Plan:
- Reset, then hart0 and hart1 both valid, cop_ready=1, accept=wb=1 → hart0 is granted with tag 0, then hart1 with tag 1; pointer alternates 0,1,0.
- cop_ready=0 for 3 cycles with hart1 granted, then hart0 asserts valid → grant stays on hart1 until handshake; cop_instr_o is stable.
- Fill 4 slots with results withheld → cop_valid_o=0 and req_ready_o=0. Return tag 2 → issue is blocked that cycle and allocates tag 2 the next cycle.
- Result tag 1 (owned by hart1, id 5) with hart_res_ready_i[1]=0 for 2 cycles → hart_res_valid_o=2'b10, hart_res_id_o=5, res_ready_o=0; the slot frees on the ready cycle.
- accept=1, writeback=0 → req_accept_o=1, no slot is allocated, next tag is still 0.
- Result for free tag 3 → res_ready_o=1, tag_err_o=1 for one cycle. Assert rst_i with 2 busy slots → all free, pointer 0.

Source files
------------

// File: rtl/cvxif_arb_pkg.sv
// cvxif_arb_pkg: shared defaults, slot-table entry type and free-slot search
// for the cvxif issue arbiter.
package cvxif_arb_pkg;
    localparam int NUM_REQ    = 2;
    localparam int NUM_SLOTS  = 4;
    localparam int ID_WIDTH   = 3;
    localparam int HART_WIDTH = $clog2(NUM_REQ);
    localparam int TAG_WIDTH  = $clog2(NUM_SLOTS);

    typedef struct packed {
        logic                  busy;
        logic [HART_WIDTH-1:0] hart;
        logic [ID_WIDTH-1:0]   id;
    } slot_entry_t;

    function automatic logic [TAG_WIDTH-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
        lowest_free = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) lowest_free = TAG_WIDTH'(i);
        end
    endfunction
endpackage

// File: rtl/cvxif_issue_arbiter_if.sv
// cvxif_issue_arbiter_if: per-hart issue/result signals plus the single
// coprocessor issue/result port; slave is the arbiter's view.
interface cvxif_issue_arbiter_if import cvxif_arb_pkg::*; #(
    parameter int NumReq   = NUM_REQ,
    parameter int NumSlots = NUM_SLOTS,
    parameter int IdWidth  = ID_WIDTH,
    localparam int TagWidth = $clog2(NumSlots)
);
    logic [NumReq-1:0]              req_valid_i;
    logic [NumReq-1:0]              req_ready_o;
    logic [NumReq-1:0][31:0]        req_instr_i;
    logic [NumReq-1:0][IdWidth-1:0] req_id_i;
    logic [NumReq-1:0]              req_accept_o;
    logic [NumReq-1:0]              req_writeback_o;
    logic                           cop_valid_o;
    logic                           cop_ready_i;
    logic [31:0]                    cop_instr_o;
    logic [TagWidth-1:0]            cop_tag_o;
    logic                           cop_accept_i;
    logic                           cop_writeback_i;
    logic                           res_valid_i;
    logic                           res_ready_o;
    logic [TagWidth-1:0]            res_tag_i;
    logic [63:0]                    res_data_i;
    logic [NumReq-1:0]              hart_res_valid_o;
    logic [NumReq-1:0]              hart_res_ready_i;
    logic [IdWidth-1:0]             hart_res_id_o;
    logic [63:0]                    hart_res_data_o;
    logic                           tag_err_o;

    modport slave (
        input  req_valid_i, req_instr_i, req_id_i, cop_ready_i, cop_accept_i, cop_writeback_i,
               res_valid_i, res_tag_i, res_data_i, hart_res_ready_i,
        output req_ready_o, req_accept_o, req_writeback_o, cop_valid_o, cop_instr_o, cop_tag_o,
               res_ready_o, hart_res_valid_o, hart_res_id_o, hart_res_data_o, tag_err_o
    );
    modport master (
        output req_valid_i, req_instr_i, req_id_i, cop_ready_i, cop_accept_i, cop_writeback_i,
               res_valid_i, res_tag_i, res_data_i, hart_res_ready_i,
        input  req_ready_o, req_accept_o, req_writeback_o, cop_valid_o, cop_instr_o, cop_tag_o,
               res_ready_o, hart_res_valid_o, hart_res_id_o, hart_res_data_o, tag_err_o
    );
endinterface

// File: rtl/cvxif_issue_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first valid requester at or after a rotating pointer;
// the previous grant is held while the issue is stalled.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] valid_i,
    input  logic         lock_i,
    input  logic         advance_i,
    output logic [W-1:0] grant_o,
    output logic         grant_valid_o
);
    logic [W-1:0] r_ptr, r_held, w_pick, w_k;
    logic         r_lock;

    always_comb begin
        w_pick = r_ptr;
        w_k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = W'((int'(r_ptr) + i) % N);
            if (valid_i[w_k]) w_pick = w_k;
        end
        grant_o = r_lock ? r_held : w_pick;
        grant_valid_o = valid_i[grant_o];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr  <= '0;
            r_held <= '0;
            r_lock <= 1'b0;
        end else begin
            r_lock <= lock_i;
            r_held <= grant_o;
            if (advance_i) r_ptr <= (grant_o == W'(N - 1)) ? '0 : grant_o + 1'b1;
        end
    end
endmodule

// File: rtl/cvxif_issue_arbiter.sv
// cvxif_issue_arbiter: shares one coprocessor among harts, remapping hart IDs to
// slot tags on issue and routing tagged results back to the owning hart.
module cvxif_issue_arbiter import cvxif_arb_pkg::*; #(
    parameter int NumReq   = NUM_REQ,
    parameter int NumSlots = NUM_SLOTS,
    parameter int IdWidth  = ID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cvxif_issue_arbiter_if.slave  bus
);
    slot_entry_t                 r_slots [NumSlots];
    slot_entry_t                 w_res_slot;
    logic [NumSlots-1:0]         w_busy;
    logic [$clog2(NumSlots)-1:0] w_free;
    logic [$clog2(NumReq)-1:0]   w_win;
    logic [IdWidth-1:0]          w_res_id;
    logic w_gv, w_full, w_issue, w_hs, w_lock, w_res_hs;

    rr_arbiter #(.N(NumReq)) u_rr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (bus.req_valid_i),
        .lock_i        (w_lock),
        .advance_i     (w_hs),
        .grant_o       (w_win),
        .grant_valid_o (w_gv)
    );

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NumSlots; i++) w_busy[i] = r_slots[i].busy;
        w_free = lowest_free(w_busy);
        w_full = &w_busy;
        w_issue = w_gv & !w_full & !rst_i;
        w_hs = w_issue & bus.cop_ready_i;
        w_lock = w_issue & !bus.cop_ready_i;
        bus.cop_valid_o = w_issue;
        bus.cop_instr_o = bus.req_instr_i[w_win];
        bus.cop_tag_o = w_free;
        bus.req_ready_o = '0;
        bus.req_accept_o = '0;
        bus.req_writeback_o = '0;
        bus.req_ready_o[w_win] = bus.cop_ready_i & !w_full & !rst_i;
        bus.req_accept_o[w_win] = w_hs & bus.cop_accept_i;
        bus.req_writeback_o[w_win] = w_hs & bus.cop_writeback_i;
        // Results for free slots are consumed and dropped so the coprocessor never stalls on them.
        w_res_slot = r_slots[bus.res_tag_i];
        w_res_id = w_res_slot.busy ? w_res_slot.id : '0;
        bus.hart_res_valid_o = '0;
        bus.hart_res_valid_o[w_res_slot.hart] = bus.res_valid_i & w_res_slot.busy & !rst_i;
        bus.res_ready_o = !rst_i & (w_res_slot.busy ? bus.hart_res_ready_i[w_res_slot.hart] : bus.res_valid_i);
        bus.tag_err_o = !rst_i & bus.res_valid_i & !w_res_slot.busy;
        bus.hart_res_id_o = w_res_id;
        bus.hart_res_data_o = bus.res_data_i;
        w_res_hs = bus.res_valid_i & bus.res_ready_o & w_res_slot.busy;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSlots; i++) r_slots[i] <= '0;
        end else begin
            if (w_res_hs) r_slots[bus.res_tag_i].busy <= 1'b0;
            if (w_hs & bus.cop_accept_i & bus.cop_writeback_i)
                r_slots[w_free] <= slot_entry_t'{busy: 1'b1, hart: w_win, id: bus.req_id_i[w_win]};
        end
    end
endmodule
